tcm_port_arbiter: RTL and testbench
===================================

Name: tcm_port_arbiter

Overview:
- Parametrised N-requestor arbiter that multiplexes several memory masters onto one single-ported TCM RAM port.
- Typical masters: core data port, AXI target bridge and a future DMA.
- Successor to the fixed two-path TCM sharing: generalised port count, data width and RAM latency, with selectable fixed-priority or round-robin arbitration.
- Every accepted request gets exactly one ack with in-order response tracking.

Parameters:
NUM_PORTS, 3, number of requestor ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); strobe width STRB_W = DATA_W/8
RAM_LATENCY, 1, fixed RAM read latency in cycles (1..4)
ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round robin

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_rd_i  in  NUM_PORTS  per-port read request
req_wr_i  in  NUM_PORTS*STRB_W  per-port byte write strobes; non-zero = write request
req_addr_i  in  NUM_PORTS*ADDR_W  per-port address, packed port 0 in LSBs
req_data_wr_i  in  NUM_PORTS*DATA_W  per-port write data
req_accept_o  out  NUM_PORTS  request accepted this cycle (one-hot or zero)
req_ack_o  out  NUM_PORTS  response strobe for port i
req_data_rd_o  out  DATA_W  shared read data, valid with a read ack
ram_accept_i  in  1  RAM can take a request this cycle
ram_rd_o  out  1  RAM read
ram_wr_o  out  STRB_W  RAM byte write enables
ram_addr_o  out  ADDR_W  RAM address
ram_data_wr_o  out  DATA_W  RAM write data
ram_data_rd_i  in  DATA_W  RAM read data, RAM_LATENCY cycles after issue

Behaviour:
- Port i requests when req_rd_i[i] | (|req_wr_i[i]).
- A request is held stable until accepted; the arbiter does not check this.
- Grant is combinational in the same cycle:
  - No grant when ram_accept_i = 0.
  - Otherwise exactly one requesting port is granted; req_accept_o is one-hot on it.
  - ram_* outputs carry the granted port's fields.
  - With no grant: ram_rd_o = 0, ram_wr_o = 0, ram_addr_o / ram_data_wr_o = 0.
- Read and write requested together on one port: treated as a write; ram_rd_o = 0, ram_wr_o = strobes.
- ARB_MODE 0: lowest-index requesting port wins.
- ARB_MODE 1: registered last-grant pointer.
  - Search starts at last+1 (mod NUM_PORTS); wrap-around required.
  - Pointer updates only on a grant.
  - Reset value NUM_PORTS-1, so port 0 wins the first contention.
- Response tracking: RAM_LATENCY-stage shift register of {valid, port id, is_read}.
  - Advances every cycle unconditionally.
  - Stage 0 is loaded with the grant (valid = 0 if no grant).
- Final stage valid:
  - req_ack_o[id] = 1 for one cycle.
  - req_data_rd_o = ram_data_rd_i if is_read, else 0.
- Final stage invalid: req_ack_o = 0, req_data_rd_o = 0.
- Throughput: one request per cycle; back-to-back grants to the same or different ports are allowed.
- Acks return in grant order, exactly RAM_LATENCY cycles after accept; an accept and an unrelated ack can occur in the same cycle.
- Reset:
  - All pipeline valids cleared; RR pointer = NUM_PORTS-1; req_ack_o = 0; req_data_rd_o = 0.
  - Reset asserted mid-flight drops in-flight responses: no ack after reset release for pre-reset grants.
- No internal queuing: a denied port stays pending with req_accept_o = 0.

Test Plan:
- Single read: port 1 rd, addr 0x100, RAM returns 0xDEADBEEF, RAM_LATENCY=1 -> accept[1] in cycle 0; ack[1] and data 0xDEADBEEF in cycle 1; no other acks.
- Fixed priority contention, ARB_MODE=0: ports 0,1,2 request continuously -> port 0 accepted every cycle; ports 1, 2 never accepted until port 0 drops.
- Round robin, ARB_MODE=1, all 3 requesting for 6 cycles -> grant order 0,1,2,0,1,2; acks follow in the same order with latency RAM_LATENCY.
- Backpressure: ram_accept_i=0 for 3 cycles while port 2 writes strobe 0xF -> accept and ram_wr_o both 0; on ram_accept_i=1, accept[2] and ram_wr_o=0xF same cycle; ack[2] one latency later with req_data_rd_o=0.
- Mixed rd+wr on one port (rd=1, wr=0x3) -> ram_rd_o=0, ram_wr_o=0x3; ack carries data 0.
- Reset mid-flight, RAM_LATENCY=3: grant port 0, assert rst_i in the next cycle -> no ack[0] ever; RR pointer restarts so port 0 wins the next contention.

Source files
------------

// File: rtl/tcm_port_arbiter.sv
// rtl/tcm_port_arbiter.sv - N-port arbiter sharing one single-ported TCM RAM port
module tcm_port_arbiter #(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1,
    parameter int ARB_MODE    = 0,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_rd_i,
    input  logic [NUM_PORTS*STRB_W-1:0]   req_wr_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_wr_i,
    output logic [NUM_PORTS-1:0]          req_accept_o,
    output logic [NUM_PORTS-1:0]          req_ack_o,
    output logic [DATA_W-1:0]             req_data_rd_o,
    input  logic                          ram_accept_i,
    output logic                          ram_rd_o,
    output logic [STRB_W-1:0]             ram_wr_o,
    output logic [ADDR_W-1:0]             ram_addr_o,
    output logic [DATA_W-1:0]             ram_data_wr_o,
    input  logic [DATA_W-1:0]             ram_data_rd_i
);

    localparam int ID_W = $clog2(NUM_PORTS);
    localparam int LAST = RAM_LATENCY - 1;

    logic [NUM_PORTS-1:0] req_valid;
    logic [ID_W-1:0]      last_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_found;
    logic                 grant;
    logic [STRB_W-1:0]    grant_strb;
    int                   start_idx;
    int                   cand;

    // Response tracking pipeline: one entry per cycle of RAM latency.
    logic                 pipe_valid [RAM_LATENCY];
    logic [ID_W-1:0]      pipe_id    [RAM_LATENCY];
    logic                 pipe_rd    [RAM_LATENCY];

    // A port is requesting when it reads or drives any byte strobe.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_valid[i] = req_rd_i[i] | (|req_wr_i[i*STRB_W +: STRB_W]);
        end
    end

    // Pick the first requester searching upward from the start index, with wrap.
    // Fixed priority always starts at port 0; round robin starts after the last grant.
    always_comb begin
        start_idx   = 0;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        if (ARB_MODE == 1) begin
            start_idx = (int'(last_ptr) + 1) % NUM_PORTS;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (start_idx + k) % NUM_PORTS;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    assign grant      = grant_found & ram_accept_i;
    assign grant_strb = req_wr_i[grant_idx*STRB_W +: STRB_W];

    // Route the granted port onto the RAM; a write strobe overrides a read on the same port.
    always_comb begin
        req_accept_o  = '0;
        ram_rd_o      = 1'b0;
        ram_wr_o      = '0;
        ram_addr_o    = '0;
        ram_data_wr_o = '0;
        if (grant) begin
            req_accept_o[grant_idx] = 1'b1;
            ram_wr_o                = grant_strb;
            ram_rd_o                = ~(|grant_strb);
            ram_addr_o              = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
            ram_data_wr_o           = req_data_wr_i[grant_idx*DATA_W +: DATA_W];
        end
    end

    // Last-grant pointer; reset value makes port 0 win the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_ptr <= ID_W'(NUM_PORTS - 1);
        end else if (grant) begin
            last_ptr <= grant_idx;
        end
    end

    // Shift the grant record every cycle so acks land exactly RAM_LATENCY cycles later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < RAM_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_id[s]    <= '0;
                pipe_rd[s]    <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= grant;
            pipe_id[0]    <= grant_idx;
            pipe_rd[0]    <= grant & ~(|grant_strb);
            for (int s = 1; s < RAM_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
                pipe_rd[s]    <= pipe_rd[s-1];
            end
        end
    end

    // Final stage drives the ack strobe and gates read data to read responses only.
    always_comb begin
        req_ack_o     = '0;
        req_data_rd_o = '0;
        if (pipe_valid[LAST]) begin
            req_ack_o[pipe_id[LAST]] = 1'b1;
            if (pipe_rd[LAST]) begin
                req_data_rd_o = ram_data_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// tb/tb_tcm_port_arbiter.sv - scoreboard bench for tcm_port_arbiter
module tb_tcm_port_arbiter;

    localparam logic [31:0] FP_RDATA = 32'hDEADBEEF;
    localparam logic [31:0] RR_RDATA = 32'h12345678;
    localparam int          FP_LAT   = 1;
    localparam int          RR_LAT   = 3;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_fp[$];
    exp_t q_rr[$];

    logic [2:0]  fp_rd, rr_rd;
    logic [11:0] fp_wr, rr_wr;
    logic [95:0] fp_addr, rr_addr, fp_wdata, rr_wdata;
    logic [2:0]  fp_accept, rr_accept, fp_ack, rr_ack;
    logic [31:0] fp_rdata, rr_rdata;
    logic        fp_ram_accept, rr_ram_accept, fp_ram_rd, rr_ram_rd;
    logic [3:0]  fp_ram_wr, rr_ram_wr;
    logic [31:0] fp_ram_addr, rr_ram_addr, fp_ram_wdata, rr_ram_wdata;
    logic [31:0] fp_ram_rdata, rr_ram_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcm_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(FP_LAT), .ARB_MODE(0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(fp_rd), .req_wr_i(fp_wr), .req_addr_i(fp_addr), .req_data_wr_i(fp_wdata),
        .req_accept_o(fp_accept), .req_ack_o(fp_ack), .req_data_rd_o(fp_rdata),
        .ram_accept_i(fp_ram_accept), .ram_rd_o(fp_ram_rd), .ram_wr_o(fp_ram_wr),
        .ram_addr_o(fp_ram_addr), .ram_data_wr_o(fp_ram_wdata), .ram_data_rd_i(fp_ram_rdata)
    );

    tcm_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(RR_LAT), .ARB_MODE(1)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(rr_rd), .req_wr_i(rr_wr), .req_addr_i(rr_addr), .req_data_wr_i(rr_wdata),
        .req_accept_o(rr_accept), .req_ack_o(rr_ack), .req_data_rd_o(rr_rdata),
        .ram_accept_i(rr_ram_accept), .ram_rd_o(rr_ram_rd), .ram_wr_o(rr_ram_wr),
        .ram_addr_o(rr_ram_addr), .ram_data_wr_o(rr_ram_wdata), .ram_data_rd_i(rr_ram_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        fp_rd = '0; fp_wr = '0; fp_addr = '0; fp_wdata = '0;
        rr_rd = '0; rr_wr = '0; rr_addr = '0; rr_wdata = '0;
    endtask

    task automatic set_port(input bit rr, input int p, input logic rd, input logic [3:0] wr,
                            input logic [31:0] a, input logic [31:0] d);
        if (rr) begin
            rr_rd[p] = rd; rr_wr[p*4 +: 4] = wr; rr_addr[p*32 +: 32] = a; rr_wdata[p*32 +: 32] = d;
        end else begin
            fp_rd[p] = rd; fp_wr[p*4 +: 4] = wr; fp_addr[p*32 +: 32] = a; fp_wdata[p*32 +: 32] = d;
        end
    endtask

    // Check combinational grant outputs this cycle; queue the expected ack if tracked.
    task automatic expect_cycle(input bit rr, input string tag, input logic [2:0] acc, input int p,
                                input logic [3:0] wr, input logic [31:0] a, input logic [31:0] d,
                                input bit track);
        logic        exp_rd;
        logic [31:0] exp_data;
        exp_rd   = (acc != 3'b000) && (wr == 4'h0);
        exp_data = exp_rd ? (rr ? RR_RDATA : FP_RDATA) : 32'h0;
        @(negedge clk);
        chk({tag, "_accept"}, rr ? rr_accept : fp_accept, acc);
        chk({tag, "_ram_rd"}, rr ? rr_ram_rd : fp_ram_rd, exp_rd);
        chk({tag, "_ram_wr"}, rr ? rr_ram_wr : fp_ram_wr, wr);
        chk({tag, "_ram_addr"}, rr ? rr_ram_addr : fp_ram_addr, a);
        chk({tag, "_ram_wdata"}, rr ? rr_ram_wdata : fp_ram_wdata, d);
        if (track && acc != 3'b000) begin
            if (rr) q_rr.push_back('{p, exp_data, cyc + RR_LAT});
            else    q_fp.push_back('{p, exp_data, cyc + FP_LAT});
        end
        next_cycle();
    endtask

    task automatic idle(input bit rr, input int n);
        for (int i = 0; i < n; i++) expect_cycle(rr, "idle", 3'b000, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic monitor(input bit rr);
        exp_t        e;
        logic [2:0]  ack;
        logic [31:0] data;
        forever begin
            @(negedge clk);
            ack  = rr ? rr_ack : fp_ack;
            data = rr ? rr_rdata : fp_rdata;
            if (ack != 3'b000) begin
                if ((rr ? q_rr.size() : q_fp.size()) == 0) begin
                    chk(rr ? "rr_unexpected_ack" : "fp_unexpected_ack", ack, 0);
                end else begin
                    e = rr ? q_rr.pop_front() : q_fp.pop_front();
                    chk(rr ? "rr_ack_port" : "fp_ack_port", ack, 64'(1) << e.port);
                    chk(rr ? "rr_ack_data" : "fp_ack_data", data, e.data);
                    chk(rr ? "rr_ack_cycle" : "fp_ack_cycle", cyc, e.cyc);
                end
            end else begin
                chk(rr ? "rr_idle_data" : "fp_idle_data", data, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        fp_ram_accept = 1'b1; rr_ram_accept = 1'b1;
        fp_ram_rdata = FP_RDATA; rr_ram_rdata = RR_RDATA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_fp_ack", fp_ack, 0);
        chk("reset_fp_rdata", fp_rdata, 0);
        chk("reset_rr_ack", rr_ack, 0);
        chk("reset_rr_rdata", rr_rdata, 0);
        next_cycle();
        rst = 1'b0;
        fork
            monitor(1'b0);
            monitor(1'b1);
        join_none

        // Single read on port 1.
        set_port(0, 1, 1'b1, 4'h0, 32'h100, 32'h0);
        expect_cycle(0, "single_rd", 3'b010, 1, 4'h0, 32'h100, 32'h0, 1'b1);
        clear_all();
        idle(0, 2);

        // Fixed priority: port 0 wins continuously, then 1, then 2.
        set_port(0, 0, 1'b1, 4'h0, 32'h10, 32'h0);
        set_port(0, 1, 1'b1, 4'h0, 32'h20, 32'h0);
        set_port(0, 2, 1'b1, 4'h0, 32'h30, 32'h0);
        for (int i = 0; i < 4; i++) expect_cycle(0, "fp_p0", 3'b001, 0, 4'h0, 32'h10, 32'h0, 1'b1);
        set_port(0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_cycle(0, "fp_p1", 3'b010, 1, 4'h0, 32'h20, 32'h0, 1'b1);
        set_port(0, 1, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_cycle(0, "fp_p2", 3'b100, 2, 4'h0, 32'h30, 32'h0, 1'b1);
        clear_all();
        idle(0, 2);

        // Backpressure: port 2 write held off by the RAM.
        fp_ram_accept = 1'b0;
        set_port(0, 2, 1'b0, 4'hF, 32'h200, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) expect_cycle(0, "bp_stall", 3'b000, 0, 4'h0, 32'h0, 32'h0, 1'b0);
        fp_ram_accept = 1'b1;
        expect_cycle(0, "bp_go", 3'b100, 2, 4'hF, 32'h200, 32'hCAFEF00D, 1'b1);
        clear_all();
        idle(0, 2);

        // Read and write together on one port behaves as a write.
        set_port(0, 0, 1'b1, 4'h3, 32'h44, 32'h11112222);
        expect_cycle(0, "mixed", 3'b001, 0, 4'h3, 32'h44, 32'h11112222, 1'b1);
        clear_all();
        idle(0, 3);

        // Round robin over all three ports.
        set_port(1, 0, 1'b1, 4'h0, 32'hA0, 32'h0);
        set_port(1, 1, 1'b1, 4'h0, 32'hB0, 32'h0);
        set_port(1, 2, 1'b1, 4'h0, 32'hC0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            expect_cycle(1, "rr_all", 3'(1 << (k % 3)), k % 3, 4'h0, 32'hA0 + 32'((k % 3) * 16), 32'h0, 1'b1);
        end
        // Subset after the pointer sits on port 2: search wraps to port 1.
        set_port(1, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_cycle(1, "rr_sub", 3'b010, 1, 4'h0, 32'hB0, 32'h0, 1'b1);
        expect_cycle(1, "rr_sub", 3'b100, 2, 4'h0, 32'hC0, 32'h0, 1'b1);
        expect_cycle(1, "rr_sub", 3'b010, 1, 4'h0, 32'hB0, 32'h0, 1'b1);
        clear_all();
        idle(1, 5);

        // Reset mid-flight: grant port 0 then reset; its ack must never appear.
        set_port(1, 0, 1'b1, 4'h0, 32'h300, 32'h0);
        expect_cycle(1, "pre_rst", 3'b001, 0, 4'h0, 32'h300, 32'h0, 1'b0);
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        chk("rst_ack", rr_ack, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_ack", rr_ack, 0);
            next_cycle();
        end
        set_port(1, 0, 1'b1, 4'h0, 32'hA0, 32'h0);
        set_port(1, 1, 1'b1, 4'h0, 32'hB0, 32'h0);
        set_port(1, 2, 1'b1, 4'h0, 32'hC0, 32'h0);
        expect_cycle(1, "rr_restart", 3'b001, 0, 4'h0, 32'hA0, 32'h0, 1'b1);
        clear_all();
        idle(1, 6);

        chk("fp_queue_drained", 64'(q_fp.size()), 0);
        chk("rr_queue_drained", 64'(q_rr.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
